// File: rtl/down_counter_prog_pkg.sv
// down_counter_prog_pkg
// Shared definitions for the programmable down-counter:
//   - DEFAULT_WIDTH : default counter / load-value width
//   - state_t       : 2-bit controller state encoding
//                     (ST_IDLE=0, ST_COUNTING=1, ST_DONE=2)
package down_counter_prog_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COUNTING = 2'd1,
      ST_DONE     = 2'd2
   } state_t;

endpackage

// File: rtl/down_counter_prog_tc_detect.sv
// tc_detect
// Combinational terminal-count detector. It flags the cycle on which the
// counter, while COUNTING and enabled, is about to step from 1.
// Ports:
//   count    in  WIDTH  registered counter value
//   enable   in  1      count-enable
//   state    in  2      registered controller state
//   tc_event out 1      terminal event on the coming edge
module tc_detect
   import down_counter_prog_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] count,
   input  logic             enable,
   input  state_t           state,
   output logic             tc_event
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   assign tc_event = enable && (state == ST_COUNTING) && (count == ONE);

endmodule

// File: rtl/down_counter_prog.sv
// down_counter_prog
// Programmable loadable down-counter with terminal-count pulse and optional
// auto-reload. All state is registered on clock; zero/busy/done are decoded
// from registered state and count only.
// Ports:
//   clock       in  1      system clock, rising edge
//   reset       in  1      asynchronous active-low reset
//   enable      in  1      count-enable
//   load        in  1      synchronous load strobe (highest priority)
//   load_value  in  WIDTH  start value, also captured as reload value
//   reload_mode in  1      1 = auto-reload at terminal, 0 = one-shot
//   count       out WIDTH  current counter value
//   zero        out 1      count == 0
//   tc_pulse    out 1      one-cycle pulse after terminal event
//   busy        out 1      state is COUNTING
//   done        out 1      state is DONE (one-shot expired)
module down_counter_prog
   import down_counter_prog_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             reload_mode,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             tc_pulse,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_reg,  state_next;
   logic [WIDTH-1:0] count_reg,  count_next;
   logic [WIDTH-1:0] reload_reg, reload_next;
   logic             tc_reg,     tc_next;
   logic             tc_event;

   tc_detect #(.WIDTH(WIDTH)) u_tc_detect (
      .count    (count_reg),
      .enable   (enable),
      .state    (state_reg),
      .tc_event (tc_event)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg  <= ST_IDLE;
         count_reg  <= '0;
         reload_reg <= '0;
         tc_reg     <= 1'b0;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         reload_reg <= reload_next;
         tc_reg     <= tc_next;
      end
   end

   // Priority: load > terminal event > decrement > hold.
   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      reload_next = reload_reg;
      tc_next     = 1'b0;

      if (load) begin
         count_next  = load_value;
         reload_next = load_value;
         // A zero start value has nothing to count, so park in IDLE.
         state_next  = (load_value != '0) ? ST_COUNTING : ST_IDLE;
      end else if (tc_event) begin
         tc_next = 1'b1;
         if (reload_mode) begin
            count_next = reload_reg;
         end else begin
            count_next = '0;
            state_next = ST_DONE;
         end
      end else if ((state_reg == ST_COUNTING) && enable && (count_reg != '0)) begin
         // count_reg != 0 guard keeps the counter from ever wrapping below 0.
         count_next = count_reg - ONE;
      end
   end

   assign count    = count_reg;
   assign tc_pulse = tc_reg;
   assign zero     = (count_reg == '0);
   assign busy     = (state_reg == ST_COUNTING);
   assign done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_down_counter_prog.sv
// tb_down_counter_prog
// Self-checking bench for down_counter_prog (WIDTH=4). A behavioural model
// predicts outputs for each driven cycle and pushes them to a scoreboard
// queue; each test task pops and compares after the clock edge.
module tb_down_counter_prog;

   typedef struct packed {
      logic [3:0] cnt;
      logic       zero;
      logic       tc;
      logic       busy;
      logic       done;
   } obs_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       load;
   logic [3:0] load_value;
   logic       reload_mode;
   logic [3:0] count;
   logic       zero;
   logic       tc_pulse;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;

   obs_t sb[$];

   // reference model state: 0=IDLE 1=COUNTING 2=DONE
   logic [3:0] m_count;
   logic [3:0] m_reload;
   int         m_state;
   logic       m_tc;

   down_counter_prog #(.WIDTH(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .load        (load),
      .load_value  (load_value),
      .reload_mode (reload_mode),
      .count       (count),
      .zero        (zero),
      .tc_pulse    (tc_pulse),
      .busy        (busy),
      .done        (done)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic obs_t model_obs();
      obs_t o;
      o.cnt  = m_count;
      o.zero = (m_count == 4'd0);
      o.tc   = m_tc;
      o.busy = (m_state == 1);
      o.done = (m_state == 2);
      return o;
   endfunction

   function automatic obs_t dut_obs();
      obs_t o;
      o.cnt  = count;
      o.zero = zero;
      o.tc   = tc_pulse;
      o.busy = busy;
      o.done = done;
      return o;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("count=%0d zero=%0b tc=%0b busy=%0b done=%0b",
                       o.cnt, o.zero, o.tc, o.busy, o.done);
   endfunction

   task automatic model_reset();
      m_count  = 4'd0;
      m_reload = 4'd0;
      m_state  = 0;
      m_tc     = 1'b0;
   endtask

   // Predict the next cycle, push it, drive the inputs and advance one edge.
   task automatic step(input logic en, input logic ld, input logic [3:0] lv,
                       input logic rm);
      if (ld) begin
         m_count  = lv;
         m_reload = lv;
         m_state  = (lv != 4'd0) ? 1 : 0;
         m_tc     = 1'b0;
      end else if (m_state == 1 && en && m_count == 4'd1) begin
         m_tc = 1'b1;
         if (rm) begin
            m_count = m_reload;
         end else begin
            m_count = 4'd0;
            m_state = 2;
         end
      end else if (m_state == 1 && en && m_count != 4'd0) begin
         m_count = m_count - 4'd1;
         m_tc    = 1'b0;
      end else begin
         m_tc = 1'b0;
      end
      sb.push_back(model_obs());
      enable      = en;
      load        = ld;
      load_value  = lv;
      reload_mode = rm;
      @(posedge clock);
      #1;
      $display("txn en=%0b ld=%0b lv=%0d rm=%0b -> %s", en, ld, lv, rm, fmt(dut_obs()));
   endtask

   task automatic test_reset();
      obs_t e, o;
      // power-on reset state
      checks++;
      o = dut_obs();
      if (o !== 9'b0000_1_0_0_0) begin
         failures++;
         $display("FAIL reset_initial got %s required count=0 zero=1 tc=0 busy=0 done=0", fmt(o));
      end
      reset = 1'b1;
      model_reset();
      step(1'b0, 1'b1, 4'd9, 1'b0);
      e = sb.pop_front(); o = dut_obs(); checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL reset_load9 got %s required %s", fmt(o), fmt(e));
      end
      // assert reset between edges; outputs must clear without a clock
      #1 reset = 1'b0;
      #1;
      o = dut_obs(); checks++;
      if (o !== 9'b0000_1_0_0_0) begin
         failures++;
         $display("FAIL reset_async got %s required count=0 zero=1 tc=0 busy=0 done=0", fmt(o));
      end
      #1 reset = 1'b1;
      model_reset();
   endtask

   task automatic test_one_shot();
      obs_t e, o;
      int pulses = 0;
      step(1'b1, 1'b1, 4'd5, 1'b0);
      for (int i = 0; i < 15; i++) begin
         if (i > 0) step(1'b1, 1'b0, 4'd0, 1'b0);
         e = sb.pop_front(); o = dut_obs(); checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL one_shot[%0d] got %s required %s", i, fmt(o), fmt(e));
         end
         if (tc_pulse) pulses++;
      end
      checks++;
      if (pulses != 1 || count !== 4'd0 || done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL one_shot_summary got pulses=%0d %s required pulses=1 count=0 done=1 busy=0",
                  pulses, fmt(dut_obs()));
      end
   endtask

   task automatic test_gated_enable();
      obs_t e, o;
      logic en_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [3:0] cnt_exp [5] = '{4'd2, 4'd2, 4'd2, 4'd1, 4'd0};
      int pulses = 0;
      step(1'b0, 1'b1, 4'd3, 1'b0);
      e = sb.pop_front(); o = dut_obs(); checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL gated_load got %s required %s", fmt(o), fmt(e));
      end
      for (int i = 0; i < 5; i++) begin
         step(en_pat[i], 1'b0, 4'd0, 1'b0);
         e = sb.pop_front(); o = dut_obs(); checks++;
         if (o !== e || o.cnt !== cnt_exp[i]) begin
            failures++;
            $display("FAIL gated[%0d] got %s required %s", i, fmt(o), fmt(e));
         end
         if (tc_pulse) pulses++;
      end
      checks++;
      if (pulses != 1 || tc_pulse !== 1'b1) begin
         failures++;
         $display("FAIL gated_pulses got pulses=%0d last_tc=%0b required pulses=1 last_tc=1", pulses, tc_pulse);
      end
   endtask

   task automatic test_auto_reload();
      obs_t e, o;
      int pulses = 0;
      step(1'b0, 1'b1, 4'd4, 1'b1);
      void'(sb.pop_front());
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b0, 4'd0, 1'b1);
         e = sb.pop_front(); o = dut_obs(); checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL auto_reload[%0d] got %s required %s", i, fmt(o), fmt(e));
         end
         if (tc_pulse) pulses++;
      end
      checks++;
      if (pulses != 3 || count !== 4'd4 || busy !== 1'b1) begin
         failures++;
         $display("FAIL auto_reload_summary got pulses=%0d count=%0d busy=%0b required pulses=3 count=4 busy=1",
                  pulses, count, busy);
      end
   endtask

   task automatic test_simultaneous();
      obs_t e, o;
      step(1'b0, 1'b1, 4'd1, 1'b0);
      void'(sb.pop_front());
      // load coincides with a would-be terminal event
      step(1'b1, 1'b1, 4'd7, 1'b0);
      e = sb.pop_front(); o = dut_obs(); checks++;
      if (o !== e || o !== 9'b0111_0_0_1_0) begin
         failures++;
         $display("FAIL simul_load7 got %s required count=7 zero=0 tc=0 busy=1 done=0", fmt(o));
      end
      step(1'b1, 1'b1, 4'd0, 1'b0);
      e = sb.pop_front(); o = dut_obs(); checks++;
      if (o !== e || o !== 9'b0000_1_0_0_0) begin
         failures++;
         $display("FAIL simul_load0 got %s required count=0 zero=1 tc=0 busy=0 done=0", fmt(o));
      end
      // enable ignored in IDLE
      step(1'b1, 1'b0, 4'd0, 1'b0);
      e = sb.pop_front(); o = dut_obs(); checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL idle_hold got %s required %s", fmt(o), fmt(e));
      end
   endtask

   task automatic test_boundary();
      obs_t e, o;
      int tc_cycle = -1;
      step(1'b0, 1'b1, 4'd15, 1'b0);
      void'(sb.pop_front());
      for (int i = 1; i <= 18; i++) begin
         step(1'b1, 1'b0, 4'd0, 1'b0);
         e = sb.pop_front(); o = dut_obs(); checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL boundary[%0d] got %s required %s", i, fmt(o), fmt(e));
         end
         if (tc_pulse && tc_cycle < 0) tc_cycle = i;
      end
      checks++;
      if (tc_cycle != 15) begin
         failures++;
         $display("FAIL boundary_tc_cycle got %0d required 15", tc_cycle);
      end
      // load in DONE clears done
      step(1'b0, 1'b1, 4'd2, 1'b0);
      e = sb.pop_front(); o = dut_obs(); checks++;
      if (o !== e || done !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL done_clear got %s required %s", fmt(o), fmt(e));
      end
   endtask

   task automatic test_back_to_back();
      obs_t e, o;
      // reload value 1: a pulse on every enabled cycle, count pinned at 1
      step(1'b0, 1'b1, 4'd1, 1'b1);
      void'(sb.pop_front());
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 4'd0, 1'b1);
         e = sb.pop_front(); o = dut_obs(); checks++;
         if (o !== e || o !== 9'b0001_0_1_1_0) begin
            failures++;
            $display("FAIL reload_one[%0d] got %s required count=1 zero=0 tc=1 busy=1 done=0", i, fmt(o));
         end
      end
      // switch to one-shot mid-run: next terminal ends in DONE
      step(1'b1, 1'b0, 4'd0, 1'b0);
      e = sb.pop_front(); o = dut_obs(); checks++;
      if (o !== e || o !== 9'b0000_1_1_0_1) begin
         failures++;
         $display("FAIL mode_switch got %s required count=0 zero=1 tc=1 busy=0 done=1", fmt(o));
      end
   endtask

   initial begin
      reset       = 1'b0;
      enable      = 1'b0;
      load        = 1'b0;
      load_value  = 4'd0;
      reload_mode = 1'b0;
      model_reset();
      #12;
      test_reset();
      test_one_shot();
      test_gated_enable();
      test_auto_reload();
      test_simultaneous();
      test_boundary();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
